// File: rtl/spi_burst_reader_if.sv
// Bus bundle for spi_burst_reader.
// Carries the SPI master core register port (m_*) and the received-byte
// valid/ready stream (out_*).
//   master : the burst reader (drives core strobes and the out stream)
//   slave  : the SPI core plus the downstream byte consumer
interface spi_burst_reader_if;
    logic        m_select;
    logic [2:0]  m_addr;
    logic        m_read_n;
    logic        m_write_n;
    logic [15:0] m_wrdata;
    logic [15:0] m_rddata;
    logic        m_dataavailable;
    logic        m_readyfordata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output m_select, m_addr, m_read_n, m_write_n, m_wrdata,
        output out_data, out_valid,
        input  m_rddata, m_dataavailable, m_readyfordata,
        input  out_ready
    );

    modport slave (
        input  m_select, m_addr, m_read_n, m_write_n, m_wrdata,
        input  out_data, out_valid,
        output m_rddata, m_dataavailable, m_readyfordata,
        output out_ready
    );
endinterface

// File: rtl/spi_burst_reader.sv
// SPI burst read sequencer.
// Runs one chip-selected SPI read through the SPI master core register port:
// opcode, 24-bit address (MSB byte first), DUMMY_BYTES zero bytes, then len
// data bytes which are handed out on an 8-bit valid/ready stream.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             one-cycle request, only sampled while idle
//   cmd, addr, len    transaction parameters, latched on accepted start
//   busy, done, error status; error is meaningful together with done
//   bus (master)      SPI core register port and output byte stream
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start
// S_SS_ON   | write control reg (addr 3) = 0x0400, slave select on
// S_HDR     | wait TRDY, write header byte hdr_idx to tx reg (addr 1)
// S_WAIT_RX | wait RRDY with timeout
// S_RD      | read rx reg (addr 0); header bytes discarded, data kept
// S_DATA    | wait TRDY, write 0xFF to tx reg to clock in a data byte
// S_OUT     | present byte on out stream until accepted
// S_SS_OFF  | write control reg = 0x0000, slave select off
// S_FIN     | one-cycle done pulse
module spi_burst_reader #(
    parameter int LEN_W       = 16,
    parameter int DUMMY_BYTES = 0,
    parameter int TIMEOUT     = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       cmd,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             error,
    spi_burst_reader_if.master bus
);

    localparam int HDR_LAST = 3 + DUMMY_BYTES;
    localparam int TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SS_ON,
        S_HDR,
        S_WAIT_RX,
        S_RD,
        S_DATA,
        S_OUT,
        S_SS_OFF,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [23:0]      addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [4:0]       hdr_idx_q, hdr_idx_d;
    logic             data_ph_q, data_ph_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [7:0]       out_data_q, out_data_d;

    logic             in_acc;
    logic             acc_gate;
    logic             acc_last;
    logic             acc_wr;
    logic [2:0]       acc_addr;
    logic [15:0]      acc_data;
    logic             strobe;
    logic [7:0]       hdr_byte;

    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_idx_q)
            5'd0:    hdr_byte = cmd_q;
            5'd1:    hdr_byte = addr_q[23:16];
            5'd2:    hdr_byte = addr_q[15:8];
            5'd3:    hdr_byte = addr_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            phase_q    <= 2'd0;
            cmd_q      <= 8'h00;
            addr_q     <= 24'h0;
            len_q      <= '0;
            hdr_idx_q  <= 5'd0;
            data_ph_q  <= 1'b0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            out_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            hdr_idx_q  <= hdr_idx_d;
            data_ph_q  <= data_ph_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
        end
    end

    // Every register access walks phase 0..3: phase 0 waits for acc_gate,
    // phases 1-2 hold the strobe, phase 3 is the mandatory idle cycle. The
    // 2-bit phase wraps back to 0 as the state moves on.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        len_d      = len_q;
        hdr_idx_d  = hdr_idx_q;
        data_ph_d  = data_ph_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        out_data_d = out_data_q;
        in_acc     = 1'b0;
        acc_gate   = 1'b1;
        acc_wr     = 1'b0;
        acc_addr   = 3'd0;
        acc_data   = 16'h0000;
        acc_last   = (phase_q == 2'd3);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmd_d     = cmd;
                    addr_d    = addr;
                    len_d     = len;
                    hdr_idx_d = 5'd0;
                    data_ph_d = 1'b0;
                    err_d     = 1'b0;
                    state_d   = S_SS_ON;
                end
            end
            S_SS_ON: begin
                in_acc   = 1'b1;
                acc_wr   = 1'b1;
                acc_addr = 3'd3;
                acc_data = 16'h0400;
                if (acc_last) state_d = S_HDR;
            end
            S_HDR: begin
                in_acc   = 1'b1;
                acc_gate = bus.m_readyfordata;
                acc_wr   = 1'b1;
                acc_addr = 3'd1;
                acc_data = {8'h00, hdr_byte};
                if (acc_last) begin
                    tmo_d   = TMO_W'(TIMEOUT);
                    state_d = S_WAIT_RX;
                end
            end
            S_WAIT_RX: begin
                if (bus.m_dataavailable) begin
                    state_d = S_RD;
                end else if (tmo_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_SS_OFF;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            S_RD: begin
                in_acc   = 1'b1;
                acc_addr = 3'd0;
                if (phase_q == 2'd2 && data_ph_q) out_data_d = bus.m_rddata[7:0];
                if (acc_last) begin
                    if (data_ph_q) begin
                        state_d = S_OUT;
                    end else if (hdr_idx_q == 5'(HDR_LAST)) begin
                        if (len_q == '0) begin
                            state_d = S_SS_OFF;
                        end else begin
                            data_ph_d = 1'b1;
                            state_d   = S_DATA;
                        end
                    end else begin
                        hdr_idx_d = hdr_idx_q + 5'd1;
                        state_d   = S_HDR;
                    end
                end
            end
            S_DATA: begin
                in_acc   = 1'b1;
                acc_gate = bus.m_readyfordata;
                acc_wr   = 1'b1;
                acc_addr = 3'd1;
                acc_data = 16'h00FF;
                if (acc_last) begin
                    tmo_d   = TMO_W'(TIMEOUT);
                    state_d = S_WAIT_RX;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    len_d   = len_q - LEN_W'(1);
                    state_d = (len_q == LEN_W'(1)) ? S_SS_OFF : S_DATA;
                end
            end
            S_SS_OFF: begin
                in_acc   = 1'b1;
                acc_wr   = 1'b1;
                acc_addr = 3'd3;
                acc_data = 16'h0000;
                if (acc_last) state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (in_acc && (phase_q != 2'd0 || acc_gate)) phase_d = phase_q + 2'd1;
        strobe = in_acc && (phase_q == 2'd1 || phase_q == 2'd2);
    end

    assign bus.m_select  = strobe;
    assign bus.m_addr    = strobe ? acc_addr : 3'd0;
    assign bus.m_write_n = ~(strobe & acc_wr);
    assign bus.m_read_n  = ~(strobe & ~acc_wr);
    assign bus.m_wrdata  = (strobe & acc_wr) ? acc_data : 16'h0000;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = (state_q == S_OUT);

    assign busy  = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done  = (state_q == S_FIN);
    assign error = err_q;

endmodule
